// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port RAM between the IF and MEM stages.
// MEM has priority; IF is forced through after STARVE_MAX back-to-back MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic       owner_if;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       grant_if;

    assign grant_if  = if_req && (!mem_req || starve_cnt == 4'(STARVE_MAX));
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_sel    <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ack     <= 1'b0;
            mem_ack    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_req || if_req) begin
                        owner_if  <= grant_if;
                        lat_cnt   <= 4'(RAM_LAT - 1);
                        ram_ce    <= 1'b1;
                        ram_addr  <= grant_if ? if_addr : mem_addr;
                        ram_we    <= !grant_if && mem_we;
                        ram_sel   <= grant_if ? 4'hF : mem_sel;
                        ram_wdata <= grant_if ? '0 : mem_wdata;
                        // Count only MEM wins that left IF waiting
                        if (grant_if || !if_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != 4'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 4'd1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        ram_ce <= 1'b0;
                        if (owner_if) begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_rdata;
                        end else begin
                            mem_ack <= 1'b1;
                            if (!ram_we)
                                mem_rdata <= ram_rdata;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if_ack  <= 1'b0;
                    mem_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ram_ce;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: a grant opens a window of LAT enable cycles,
    // then one ack cycle, then one dead cycle before the next grant.
    logic        e_ce, e_we, e_if_ack, e_mem_ack;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_mem_rdata;
    bit          m_busy, m_if;
    int          k, starve;

    always @(posedge clk) begin
        if (rst) begin
            e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
            e_if_rdata = 0; e_mem_rdata = 0; e_if_ack = 0; e_mem_ack = 0;
            m_busy = 0; m_if = 0; k = 0; starve = 0;
        end else if (!m_busy) begin
            if (mem_req || if_req) begin
                m_if = if_req && (!mem_req || starve == SMAX);
                if (m_if || !if_req) starve = 0;
                else starve = (starve < SMAX) ? starve + 1 : starve;
                e_ce    = 1;
                e_addr  = m_if ? if_addr : mem_addr;
                e_we    = m_if ? 1'b0 : mem_we;
                e_sel   = m_if ? 4'hF : mem_sel;
                e_wdata = m_if ? 32'h0 : mem_wdata;
                m_busy  = 1;
                k       = 0;
            end
        end else begin
            k++;
            if (k == LAT) begin
                e_ce = 0;
                if (m_if) begin
                    e_if_ack   = 1;
                    e_if_rdata = ram_rdata;
                end else begin
                    e_mem_ack = 1;
                    if (!e_we) e_mem_rdata = ram_rdata;
                end
            end else if (k == LAT + 1) begin
                e_if_ack  = 0;
                e_mem_ack = 0;
                m_busy    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk1("ce", ram_ce, e_ce);
            chk1("we", ram_we, e_we);
            chk("sel", 32'(ram_sel), 32'(e_sel));
            chk("addr", ram_addr, e_addr);
            chk("wdata", ram_wdata, e_wdata);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("mem_rdata", mem_rdata, e_mem_rdata);
            chk1("if_ack", if_ack, e_if_ack);
            chk1("mem_ack", mem_ack, e_mem_ack);
            chk1("busy", busy, m_busy);
            chk1("stall_if", stall_if, if_req & ~e_if_ack);
            chk1("stall_mem", stall_mem, mem_req & ~e_mem_ack);
        end
    end

    initial begin
        int acks;
        int cyc;

        if_req  = 1'($urandom);
        mem_req = 1'($urandom);
        if_addr = $urandom;
        tick();
        started = 1'b1;
        tick();
        chk1("rst_ce", ram_ce, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack", if_ack | mem_ack, 1'b0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'h0);
        rst = 0; if_req = 0; mem_req = 0;
        tick();

        // Single IF read
        if_req = 1; if_addr = 32'h10; ram_rdata = 32'hDEADBEEF;
        #1 chk1("ifrd_stall_t0", stall_if, 1'b1);
        tick();
        chk1("ifrd_ce_t1", ram_ce, 1'b1);
        chk("ifrd_addr_t1", ram_addr, 32'h10);
        chk1("ifrd_stall_t1", stall_if, 1'b1);
        tick();
        chk1("ifrd_ce_t2", ram_ce, 1'b1);
        chk1("ifrd_stall_t2", stall_if, 1'b1);
        tick();
        chk1("ifrd_ack_t3", if_ack, 1'b1);
        chk("ifrd_data_t3", if_rdata, 32'hDEADBEEF);
        chk1("ifrd_stall_t3", stall_if, 1'b0);
        chk1("ifrd_ce_t3", ram_ce, 1'b0);
        if_req = 0;
        tick();

        // Simultaneous requests: MEM first
        if_req = 1; if_addr = 32'h10;
        mem_req = 1; mem_we = 0; mem_addr = 32'h40;
        ram_rdata = 32'hCAFE0001;
        tick(); tick(); tick();
        chk1("sim_mem_ack", mem_ack, 1'b1);
        chk1("sim_if_noack", if_ack, 1'b0);
        chk("sim_mem_data", mem_rdata, 32'hCAFE0001);
        mem_req = 0;
        tick();
        chk1("sim_ce_t4", ram_ce, 1'b0);
        tick();
        chk1("sim_ce_t5", ram_ce, 1'b1);
        chk("sim_addr_t5", ram_addr, 32'h10);
        tick(); tick();
        chk1("sim_if_ack_t7", if_ack, 1'b1);
        chk("sim_if_data", if_rdata, 32'hCAFE0001);
        if_req = 0;
        tick();

        // Starvation: pattern M M M M I, twice
        if_req = 1; if_addr = 32'h14;
        mem_req = 1; mem_we = 0; mem_addr = 32'h44;
        ram_rdata = 32'h55AA55AA;
        acks = 0; cyc = 0;
        while (acks < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (mem_ack || if_ack) begin
                chk1("starve_order", if_ack, 1'(acks % 5 == 4));
                acks++;
            end
        end
        chk("starve_acks", 32'(acks), 32'd10);
        if_req = 0; mem_req = 0;
        tick();

        // MEM write leaves mem_rdata untouched
        mem_req = 1; mem_we = 1; mem_sel = 4'b0011;
        mem_addr = 32'h20; mem_wdata = 32'h1234;
        ram_rdata = 32'h0BADF00D;
        tick();
        chk1("wr_we_t1", ram_we, 1'b1);
        chk("wr_sel_t1", 32'(ram_sel), 32'h3);
        chk("wr_wdata_t1", ram_wdata, 32'h1234);
        chk("wr_addr_t1", ram_addr, 32'h20);
        tick();
        chk1("wr_ce_t2", ram_ce, 1'b1);
        chk1("wr_we_t2", ram_we, 1'b1);
        tick();
        chk1("wr_ack_t3", mem_ack, 1'b1);
        chk("wr_rdata_hold", mem_rdata, 32'h55AA55AA);
        mem_req = 0; mem_we = 0;
        tick();

        // Reset in the middle of an IF access
        if_req = 1; if_addr = 32'h30; ram_rdata = 32'h600DCAFE;
        tick();
        chk1("rmid_ce_t1", ram_ce, 1'b1);
        rst = 1;
        tick();
        chk1("rmid_ce_t2", ram_ce, 1'b0);
        chk1("rmid_busy_t2", busy, 1'b0);
        chk1("rmid_ack_t2", if_ack, 1'b0);
        chk("rmid_rdata_t2", if_rdata, 32'h0);
        rst = 0;
        tick();
        chk1("rmid_ce_t3", ram_ce, 1'b1);
        chk1("rmid_ack_t3", if_ack, 1'b0);
        tick();
        chk1("rmid_ack_t4", if_ack, 1'b0);
        tick();
        chk1("rmid_ack_t5", if_ack, 1'b1);
        chk("rmid_data_t5", if_rdata, 32'h600DCAFE);
        if_req = 0;
        tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 5 == 0) if_req = ~if_req;
            if ($urandom % 4 == 0) mem_req = ~mem_req;
            if_addr   = $urandom;
            mem_addr  = $urandom;
            mem_we    = 1'($urandom);
            mem_sel   = 4'($urandom);
            mem_wdata = $urandom;
            ram_rdata = $urandom;
            rst       = ($urandom % 150 == 0);
            tick();
        end
        rst = 0; if_req = 0; mem_req = 0;
        tick(); tick(); tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified RAM between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Sequences each RAM access: grant, hold for the RAM latency, then return read data with a one-cycle ack.
- Drives per-stage stall signals into the pipeline registers.
- Gives MEM priority, with starvation protection for IF.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RAM_LAT, 2, cycles `ram_ce` is held before `ram_rdata` is valid; legal range 1..15.
- STARVE_MAX, 4, maximum consecutive MEM grants while `if_req` is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held until `if_ack`.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  IF read data; valid when `if_ack`=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request; held until `mem_ack`.
- mem_we  in  1  1=write, 0=read.
- mem_sel  in  4  byte enables.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_rdata  out  DATA_W  MEM read data; valid when `mem_ack`=1 on a read.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_sel  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- stall_if  out  1  `if_req & ~if_ack` (combinational).
- stall_mem  out  1  `mem_req & ~mem_ack` (combinational).
- busy  out  1  1 when state is not IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If `mem_req` or `if_req` is high, pick a winner, latch owner/addr/we/sel/wdata into registers, load lat_cnt=RAM_LAT-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration: MEM wins unless starve_cnt==STARVE_MAX and `if_req`=1, in which case IF wins.
- ACCESS:
  - `ram_ce`=1 and all `ram_*` outputs are driven from the latched registers.
  - IF owner: `ram_we`=0, `ram_sel`=4'b1111, `ram_wdata`=0.
  - MEM owner: `ram_we`=latched we, `ram_sel`=latched sel, `ram_wdata`=latched wdata.
  - lat_cnt decrements each cycle. When lat_cnt==0, sample `ram_rdata` into the owner's rdata register (reads only) and go to RESP.
  - ACCESS therefore lasts exactly RAM_LAT cycles.
- RESP:
  - Owner's ack=1 for exactly one cycle; `ram_ce`=0; next state is IDLE.
  - No arbitration in RESP, so a requester never sees a stale grant.
- Latency: request seen in IDLE at cycle T → `ram_ce` at T+1..T+RAM_LAT → ack at T+RAM_LAT+1 → next grant no earlier than T+RAM_LAT+2.
- `mem_rdata` is updated only on MEM reads and holds its value across MEM writes. `if_rdata` is updated only on IF grants. Both hold between accesses.
- Starve counter (saturating at STARVE_MAX):
  - On a MEM grant with `if_req`=1: increment.
  - On a MEM grant with `if_req`=0: clear.
  - On an IF grant: clear.
- Requester drops its request before grant: no access is made.
- Requester drops its request after grant: the access completes and the ack still pulses.
- Requests are ignored outside IDLE. Input fields may change after grant; the latched copies are used.
- `mem_ack` and `if_ack` are never high in the same cycle.
- Reset (any state, including mid-ACCESS or RESP): next cycle state=IDLE and the in-flight access is abandoned with no ack. The following all read 0 after reset:
  - registered outputs: `ram_ce`, `ram_we`, `ram_sel`, `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata`, `if_ack`, `mem_ack`, `busy`
  - internal counters: lat_cnt, starve_cnt
  - `stall_*` follow their equations.

Test Plan:
- Reset: hold rst 2 cycles with random requests → all registered outputs 0, `busy`=0; after release, the first grant occurs no earlier than the cycle after rst falls.
- IF read, RAM_LAT=2: `if_req`=1, `if_addr`=0x10 at T; RAM returns 0xDEADBEEF → `ram_ce`=1 and `ram_addr`=0x10 at T+1,T+2; `if_ack`=1 with `if_rdata`=0xDEADBEEF at T+3; `stall_if`=1 at T..T+2 and 0 at T+3.
- Simultaneous requests: IF read 0x10 and MEM read 0x40 at T → MEM served first (`mem_ack` at T+3); IF granted at T+4 (`ram_addr`=0x10 at T+5); `if_ack` at T+7.
- Starvation, STARVE_MAX=4: `if_req` held while MEM re-requests immediately after every ack → exactly 4 `mem_ack`s, then `if_ack`, then MEM resumes with starve_cnt=0.
- MEM write: `mem_we`=1, `mem_sel`=4'b0011, `mem_addr`=0x20, `mem_wdata`=0x1234 → `ram_we`=1, `ram_sel`=0011, `ram_wdata`=0x1234 for 2 cycles; `mem_ack` pulses; `mem_rdata` unchanged from its previous value.
- Reset mid-ACCESS: assert rst at T+1 of an IF read → no `if_ack`, `ram_ce`=0 at T+2; after release with `if_req` still high, a full new access completes, ack arriving RAM_LAT+1 cycles after the re-grant cycle.
